// File: rtl/arm_pipeline_sequencer.sv
// Fetch/decode/execute sequencer for the ARM-state core: issues fetches, holds the decode word,
// feeds execute, stalls on busy/wait states and flushes on retiring taken branches.
module arm_pipeline_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    input  logic        exec_busy,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        decode_valid,
    output logic [31:0] decode_instruction,
    output logic [31:0] decode_pc,
    output logic        execute_valid,
    output logic [31:0] execute_instruction,
    output logic [31:0] execute_pc,
    output logic [31:0] execute_pc_plus8,
    output logic [1:0]  seq_state
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    seq_state_t  r_state;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_target;
    logic        r_fbuf_valid;
    logic [31:0] r_fbuf_data;
    logic [31:0] r_fbuf_pc;
    logic        r_dec_valid;
    logic [31:0] r_dec_insn;
    logic [31:0] r_dec_pc;
    logic        r_exe_valid;
    logic [31:0] r_exe_insn;
    logic [31:0] r_exe_pc;

    logic        w_drain;
    logic        w_fetch_req;
    logic        w_ack;
    logic        w_avail;
    logic        w_branch;
    logic        w_exe_hold;
    logic        w_exe_load;
    logic        w_dec_load;
    logic [31:0] w_new_insn;
    logic [31:0] w_new_pc;

    assign w_drain     = (r_state == S_DRAIN);
    assign w_fetch_req = w_drain || !r_fbuf_valid;
    // An ack only counts against a request that is actually on the bus.
    assign w_ack       = fetch_ack && w_fetch_req;
    assign w_avail     = w_ack || r_fbuf_valid;
    assign w_branch    = r_exe_valid && !exec_busy && branch_taken && !w_drain;
    assign w_exe_hold  = r_exe_valid && exec_busy;
    assign w_exe_load  = !w_exe_hold && w_avail && r_dec_valid;
    assign w_dec_load  = w_avail && (!r_dec_valid || w_exe_load);
    assign w_new_insn  = r_fbuf_valid ? r_fbuf_data : fetch_data;
    assign w_new_pc    = r_fbuf_valid ? r_fbuf_pc   : r_fetch_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FILL;
            r_fetch_addr <= RESET_VECTOR;
            r_target     <= 32'd0;
            r_fbuf_valid <= 1'b0;
            r_fbuf_data  <= 32'd0;
            r_fbuf_pc    <= 32'd0;
            r_dec_valid  <= 1'b0;
            r_dec_insn   <= 32'd0;
            r_dec_pc     <= 32'd0;
            r_exe_valid  <= 1'b0;
            r_exe_insn   <= 32'd0;
            r_exe_pc     <= 32'd0;
        end else if (w_drain) begin
            if (w_ack) begin
                r_state      <= S_FILL;
                r_fetch_addr <= r_target;
            end
        end else if (w_branch) begin
            r_exe_valid  <= 1'b0;
            r_dec_valid  <= 1'b0;
            r_fbuf_valid <= 1'b0;
            // A request still outstanding keeps its old address on the bus until acked.
            if (w_fetch_req && !fetch_ack) begin
                r_state  <= S_DRAIN;
                r_target <= {branch_target[31:2], 2'b00};
            end else begin
                r_state      <= S_FILL;
                r_fetch_addr <= {branch_target[31:2], 2'b00};
            end
        end else begin
            if (w_ack) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_exe_load) begin
                r_exe_valid <= 1'b1;
                r_exe_insn  <= r_dec_insn;
                r_exe_pc    <= r_dec_pc;
            end else if (!w_exe_hold) begin
                r_exe_valid <= 1'b0;
            end
            if (w_dec_load) begin
                r_dec_valid <= 1'b1;
                r_dec_insn  <= w_new_insn;
                r_dec_pc    <= w_new_pc;
            end
            if (w_dec_load && r_fbuf_valid) begin
                r_fbuf_valid <= 1'b0;
            end else if (w_ack && !w_dec_load) begin
                r_fbuf_valid <= 1'b1;
                r_fbuf_data  <= fetch_data;
                r_fbuf_pc    <= r_fetch_addr;
            end
            r_state <= (w_dec_load || r_dec_valid) ? S_RUN : S_FILL;
        end
    end

    assign fetch_req           = w_fetch_req;
    assign fetch_addr          = r_fetch_addr;
    assign decode_valid        = r_dec_valid;
    assign decode_instruction  = r_dec_insn;
    assign decode_pc           = r_dec_pc;
    assign execute_valid       = r_exe_valid;
    assign execute_instruction = r_exe_insn;
    assign execute_pc          = r_exe_pc;
    assign execute_pc_plus8    = r_exe_pc + 32'd8;
    assign seq_state           = r_state;

endmodule

// File: tb/tb_arm_pipeline_sequencer.sv
// Directed cycle-by-cycle vectors for arm_pipeline_sequencer plus a hand-written reset-in-DRAIN case.
module tb_arm_pipeline_sequencer;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        exec_busy;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        decode_valid;
    logic [31:0] decode_instruction;
    logic [31:0] decode_pc;
    logic        execute_valid;
    logic [31:0] execute_instruction;
    logic [31:0] execute_pc;
    logic [31:0] execute_pc_plus8;
    logic [1:0]  seq_state;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] MEM_KEY = 32'h5A00_0000;

    arm_pipeline_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_req           (fetch_req),
        .fetch_addr          (fetch_addr),
        .fetch_ack           (fetch_ack),
        .fetch_data          (fetch_data),
        .exec_busy           (exec_busy),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .decode_valid        (decode_valid),
        .decode_instruction  (decode_instruction),
        .decode_pc           (decode_pc),
        .execute_valid       (execute_valid),
        .execute_instruction (execute_instruction),
        .execute_pc          (execute_pc),
        .execute_pc_plus8    (execute_pc_plus8),
        .seq_state           (seq_state)
    );

    // Memory model: the word at address a is a ^ MEM_KEY.
    assign fetch_data = fetch_addr ^ MEM_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ack;
        logic        busy;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_fa;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic        e_ev;
        logic [31:0] e_epc;
        logic [1:0]  e_st;
    } vec_t;

    localparam int NV = 26;
    vec_t vec [NV];

    function automatic vec_t mk(input logic ack, input logic busy, input logic br,
                                input logic [31:0] tgt, input logic e_req,
                                input logic [31:0] e_fa, input logic e_dv,
                                input logic [31:0] e_dpc, input logic e_ev,
                                input logic [31:0] e_epc, input logic [1:0] e_st);
        vec_t v;
        v.ack = ack; v.busy = busy; v.br = br; v.tgt = tgt;
        v.e_req = e_req; v.e_fa = e_fa; v.e_dv = e_dv; v.e_dpc = e_dpc;
        v.e_ev = e_ev; v.e_epc = e_epc; v.e_st = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // Vector i: inputs driven during cycle i, outputs expected during cycle i.
        //            ack busy br  tgt            req fa            dv dpc           ev epc           st
        vec[0]  = mk(1, 0, 0, 32'h0,          1, 32'h0,         0, 32'h0,         0, 32'h0,         2'd0);
        vec[1]  = mk(1, 0, 0, 32'h0,          1, 32'h4,         1, 32'h0,         0, 32'h0,         2'd1);
        vec[2]  = mk(1, 0, 0, 32'h0,          1, 32'h8,         1, 32'h4,         1, 32'h0,         2'd1);
        vec[3]  = mk(1, 0, 0, 32'h0,          1, 32'hC,         1, 32'h8,         1, 32'h4,         2'd1);
        vec[4]  = mk(1, 1, 0, 32'h0,          1, 32'h10,        1, 32'hC,         1, 32'h8,         2'd1);
        vec[5]  = mk(0, 1, 1, 32'h500,        0, 32'h14,        1, 32'hC,         1, 32'h8,         2'd1);
        vec[6]  = mk(0, 1, 0, 32'h0,          0, 32'h14,        1, 32'hC,         1, 32'h8,         2'd1);
        vec[7]  = mk(0, 0, 0, 32'h0,          0, 32'h14,        1, 32'hC,         1, 32'h8,         2'd1);
        vec[8]  = mk(1, 0, 0, 32'h0,          1, 32'h14,        1, 32'h10,        1, 32'hC,         2'd1);
        vec[9]  = mk(1, 0, 0, 32'h0,          1, 32'h18,        1, 32'h14,        1, 32'h10,        2'd1);
        vec[10] = mk(1, 0, 1, 32'h102,        1, 32'h1C,        1, 32'h18,        1, 32'h14,        2'd1);
        vec[11] = mk(1, 0, 1, 32'h700,        1, 32'h100,       0, 32'h0,         0, 32'h0,         2'd0);
        vec[12] = mk(1, 0, 0, 32'h0,          1, 32'h104,       1, 32'h100,       0, 32'h0,         2'd1);
        vec[13] = mk(0, 0, 0, 32'h0,          1, 32'h108,       1, 32'h104,       1, 32'h100,       2'd1);
        vec[14] = mk(0, 0, 0, 32'h0,          1, 32'h108,       1, 32'h104,       0, 32'h0,         2'd1);
        vec[15] = mk(1, 0, 0, 32'h0,          1, 32'h108,       1, 32'h104,       0, 32'h0,         2'd1);
        vec[16] = mk(0, 0, 1, 32'h200,        1, 32'h10C,       1, 32'h108,       1, 32'h104,       2'd1);
        vec[17] = mk(0, 0, 0, 32'h0,          1, 32'h10C,       0, 32'h0,         0, 32'h0,         2'd2);
        vec[18] = mk(1, 0, 0, 32'h0,          1, 32'h10C,       0, 32'h0,         0, 32'h0,         2'd2);
        vec[19] = mk(1, 0, 0, 32'h0,          1, 32'h200,       0, 32'h0,         0, 32'h0,         2'd0);
        vec[20] = mk(1, 0, 0, 32'h0,          1, 32'h204,       1, 32'h200,       0, 32'h0,         2'd1);
        vec[21] = mk(1, 0, 1, 32'hFFFF_FFFF,  1, 32'h208,       1, 32'h204,       1, 32'h200,       2'd1);
        vec[22] = mk(1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         2'd0);
        vec[23] = mk(1, 0, 0, 32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         2'd1);
        vec[24] = mk(0, 0, 1, 32'h300,        1, 32'h4,         1, 32'h0,         1, 32'hFFFF_FFFC, 2'd1);
        vec[25] = mk(0, 0, 0, 32'h0,          1, 32'h4,         0, 32'h0,         0, 32'h0,         2'd2);

        reset = 1'b0;
        fetch_ack = 1'b0;
        exec_busy = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_req",   {31'd0, fetch_req},     32'd1);
        check("rst_fa",    fetch_addr,             32'h0);
        check("rst_dv",    {31'd0, decode_valid},  32'd0);
        check("rst_ev",    {31'd0, execute_valid}, 32'd0);
        check("rst_st",    {30'd0, seq_state},     32'd0);
        check("rst_dinsn", decode_instruction,     32'h0);
        $display("reset: req=%0d fa=0x%08h dv=%0d ev=%0d st=%0d",
                 fetch_req, fetch_addr, decode_valid, execute_valid, seq_state);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_req", i), {31'd0, fetch_req},     {31'd0, vec[i].e_req});
            check($sformatf("v%0d_fa", i),  fetch_addr,             vec[i].e_fa);
            check($sformatf("v%0d_dv", i),  {31'd0, decode_valid},  {31'd0, vec[i].e_dv});
            check($sformatf("v%0d_ev", i),  {31'd0, execute_valid}, {31'd0, vec[i].e_ev});
            check($sformatf("v%0d_st", i),  {30'd0, seq_state},     {30'd0, vec[i].e_st});
            if (vec[i].e_dv) begin
                check($sformatf("v%0d_dpc", i),   decode_pc,          vec[i].e_dpc);
                check($sformatf("v%0d_dinsn", i), decode_instruction, vec[i].e_dpc ^ MEM_KEY);
            end
            if (vec[i].e_ev) begin
                check($sformatf("v%0d_epc", i),   execute_pc,          vec[i].e_epc);
                check($sformatf("v%0d_einsn", i), execute_instruction, vec[i].e_epc ^ MEM_KEY);
                check($sformatf("v%0d_pc8", i),   execute_pc_plus8,    vec[i].e_epc + 32'd8);
            end
            $display("vec %0d: ack=%0d busy=%0d br=%0d | req=%0d fa=0x%08h dv=%0d dpc=0x%08h ev=%0d epc=0x%08h st=%0d",
                     i, vec[i].ack, vec[i].busy, vec[i].br, fetch_req, fetch_addr,
                     decode_valid, decode_pc, execute_valid, execute_pc, seq_state);
            fetch_ack     = vec[i].ack;
            exec_busy     = vec[i].busy;
            branch_taken  = vec[i].br;
            branch_target = vec[i].tgt;
        end

        // DUT is in DRAIN with its fetch still unacknowledged; reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, fetch_req},     32'd1);
        check("mid_rst_fa",  fetch_addr,             32'h0);
        check("mid_rst_dv",  {31'd0, decode_valid},  32'd0);
        check("mid_rst_ev",  {31'd0, execute_valid}, 32'd0);
        check("mid_rst_st",  {30'd0, seq_state},     32'd0);
        check("mid_rst_epc", execute_pc,             32'h0);
        check("mid_rst_dpc", decode_pc,              32'h0);
        $display("mid-drain reset: req=%0d fa=0x%08h dv=%0d ev=%0d st=%0d",
                 fetch_req, fetch_addr, decode_valid, execute_valid, seq_state);

        @(negedge clk);
        reset = 1'b1;
        fetch_ack = 1'b1;
        exec_busy = 1'b0;
        branch_taken = 1'b0;
        check("restart_fa0", fetch_addr, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("restart_fa%0d", k), fetch_addr, 32'(4 * k));
            check($sformatf("restart_ev%0d", k), {31'd0, execute_valid}, (k >= 2) ? 32'd1 : 32'd0);
            if (k == 2) begin
                check("restart_epc", execute_pc,       32'h0);
                check("restart_pc8", execute_pc_plus8, 32'h8);
            end
            $display("restart %0d: fa=0x%08h dv=%0d ev=%0d epc=0x%08h",
                     k, fetch_addr, decode_valid, execute_valid, execute_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
